// File: rtl/memory_write_arbiter.sv
// rtl/memory_write_arbiter.sv - shares one memory write port between a buffered loader and a req/ack core writer
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin grant under contention instead of loader priority)
module memory_write_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_memory,
  input  logic                  reset_n,
  input  logic                  loader_wr,
  input  logic [ADDR_WIDTH-1:0] loader_addr,
  input  logic [DATA_WIDTH-1:0] loader_data,
  output logic                  loader_overflow,
  input  logic                  core_req,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_data,
  output logic                  core_ack,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_LOADER, ST_CORE} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW:0]           wptr_q, wptr_d, rptr_q, rptr_d;

  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  core_ack_q, core_ack_d;
  logic                  ovf_q, ovf_d;

  logic fifo_empty, fifo_full;
  logic push, pop, drop;
  logic core_req_eff;
  logic grant_core;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = core was granted last, 0 = loader was granted last
  logic last_core_q, last_core_d;
`endif

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  // The head entry stays in the FIFO while it is being written and is popped on completion,
  // so a push into a full FIFO is still accepted when that completion lands on the same edge.
  assign pop  = (state_q == ST_LOADER) && mem_ack;
  assign push = loader_wr && (!fifo_full || pop);
  assign drop = loader_wr && fifo_full && !pop;

  // core_req is still high during the core_ack cycle; ignoring it then prevents a duplicate write.
  assign core_req_eff = core_req && !core_ack_q;

  // Loader FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_memory) begin
    if (push) begin
      fifo_addr_q[wptr_q[PW-1:0]] <= loader_addr;
      fifo_data_q[wptr_q[PW-1:0]] <= loader_data;
    end
  end

  // Next-state, grant decision and registered memory-side outputs.
  always_comb begin
    state_d    = state_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    core_ack_d = 1'b0;
    ovf_d      = ovf_q | drop;
    wptr_d     = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d     = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    grant_core = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_core_d = last_core_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (fifo_empty) begin
          grant_core = core_req_eff;
        end else if (core_req_eff) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          // A full FIFO always wins so the loader never drops a word due to the core.
          grant_core = !fifo_full && !last_core_q;
`else
          grant_core = 1'b0;
`endif
        end

        if (grant_core) begin
          state_d    = ST_CORE;
          mem_wr_d   = 1'b1;
          mem_addr_d = core_addr;
          mem_data_d = core_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_core_d = 1'b1;
`endif
        end else if (!fifo_empty) begin
          state_d    = ST_LOADER;
          mem_wr_d   = 1'b1;
          mem_addr_d = fifo_addr_q[rptr_q[PW-1:0]];
          mem_data_d = fifo_data_q[rptr_q[PW-1:0]];
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_core_d = 1'b0;
`endif
        end
      end

      ST_LOADER, ST_CORE: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_wr_d   = 1'b0;
          core_ack_d = (state_q == ST_CORE);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State and control registers; reset abandons any in-flight write.
  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      core_ack_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_core_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      core_ack_q <= core_ack_d;
      ovf_q      <= ovf_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_core_q <= last_core_d;
`endif
    end
  end

  assign mem_wr          = mem_wr_q;
  assign mem_addr        = mem_addr_q;
  assign mem_data        = mem_data_q;
  assign core_ack        = core_ack_q;
  assign loader_overflow = ovf_q;
  assign busy            = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_write_arbiter.sv
// tb/tb_memory_write_arbiter.sv - self-checking bench for memory_write_arbiter
module tb_memory_write_arbiter;

  logic        clk_memory = 1'b0;
  logic        reset_n;
  logic        loader_wr;
  logic [14:0] loader_addr;
  logic [15:0] loader_data;
  logic        loader_overflow;
  logic        core_req;
  logic [14:0] core_addr;
  logic [15:0] core_data;
  logic        core_ack;
  logic        mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  memory_write_arbiter dut (
    .clk_memory      (clk_memory),
    .reset_n         (reset_n),
    .loader_wr       (loader_wr),
    .loader_addr     (loader_addr),
    .loader_data     (loader_data),
    .loader_overflow (loader_overflow),
    .core_req        (core_req),
    .core_addr       (core_addr),
    .core_data       (core_data),
    .core_ack        (core_ack),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .mem_ack         (mem_ack),
    .busy            (busy)
  );

  always #5 clk_memory = ~clk_memory;

  typedef struct packed {
    logic        lw;
    logic [14:0] la;
    logic [15:0] ld;
    logic        cr;
    logic [14:0] ca;
    logic [15:0] cd;
    logic        ack;
    logic        e_wr;
    logic [14:0] e_addr;
    logic [15:0] e_data;
    logic        e_cack;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic lw, input logic [14:0] la, input logic [15:0] ld,
                              input logic cr, input logic [14:0] ca, input logic [15:0] cd,
                              input logic ack, input logic e_wr, input logic [14:0] e_addr,
                              input logic [15:0] e_data, input logic e_cack, input logic e_ovf,
                              input logic e_busy);
    vec_t v;
    v.lw = lw; v.la = la; v.ld = ld; v.cr = cr; v.ca = ca; v.cd = cd; v.ack = ack;
    v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    v.e_cack = e_cack; v.e_ovf = e_ovf; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_memory);
    #1;
  endtask

  logic [14:0] got_a [$];
  logic [15:0] got_d [$];
  logic [14:0] exp_order [3];
  int          n_cack;

  initial begin
    // single loader word, then a two-word burst, then a core handshake, then a stray mem_ack
    vecs[0]  = mk(1, 15'h00C, 16'hBBAA, 0, 15'h000, 16'h0000, 1, 0, 15'h000, 16'h0000, 0, 0, 1);
    vecs[1]  = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 1, 1, 15'h00C, 16'hBBAA, 0, 0, 1);
    vecs[2]  = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 1, 0, 15'h00C, 16'hBBAA, 0, 0, 0);
    vecs[3]  = mk(1, 15'h00C, 16'hBBAA, 0, 15'h000, 16'h0000, 1, 0, 15'h00C, 16'hBBAA, 0, 0, 1);
    vecs[4]  = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 1, 1, 15'h00C, 16'hBBAA, 0, 0, 1);
    vecs[5]  = mk(1, 15'h00E, 16'hDDCC, 0, 15'h000, 16'h0000, 1, 0, 15'h00C, 16'hBBAA, 0, 0, 1);
    vecs[6]  = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 1, 1, 15'h00E, 16'hDDCC, 0, 0, 1);
    vecs[7]  = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 1, 0, 15'h00E, 16'hDDCC, 0, 0, 0);
    vecs[8]  = mk(0, 15'h000, 16'h0000, 1, 15'h020, 16'hEEFF, 0, 1, 15'h020, 16'hEEFF, 0, 0, 1);
    vecs[9]  = mk(0, 15'h000, 16'h0000, 1, 15'h020, 16'hEEFF, 0, 1, 15'h020, 16'hEEFF, 0, 0, 1);
    vecs[10] = mk(0, 15'h000, 16'h0000, 1, 15'h020, 16'hEEFF, 0, 1, 15'h020, 16'hEEFF, 0, 0, 1);
    vecs[11] = mk(0, 15'h000, 16'h0000, 1, 15'h020, 16'hEEFF, 0, 1, 15'h020, 16'hEEFF, 0, 0, 1);
    vecs[12] = mk(0, 15'h000, 16'h0000, 1, 15'h020, 16'hEEFF, 1, 0, 15'h020, 16'hEEFF, 1, 0, 0);
    vecs[13] = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 0, 0, 15'h020, 16'hEEFF, 0, 0, 0);
    vecs[14] = mk(0, 15'h000, 16'h0000, 0, 15'h000, 16'h0000, 1, 0, 15'h020, 16'hEEFF, 0, 0, 0);

    reset_n = 1'b0;
    loader_wr = 1'b0; loader_addr = '0; loader_data = '0;
    core_req = 1'b0; core_addr = '0; core_data = '0;
    mem_ack = 1'b0;
    step();
    step();
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_data", 32'(mem_data), 32'd0);
    check("rst core_ack", 32'(core_ack), 32'd0);
    check("rst overflow", 32'(loader_overflow), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      loader_wr = vecs[i].lw; loader_addr = vecs[i].la; loader_data = vecs[i].ld;
      core_req = vecs[i].cr; core_addr = vecs[i].ca; core_data = vecs[i].cd;
      mem_ack = vecs[i].ack;
      step();
      check($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].e_wr));
      check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d mem_data", i), 32'(mem_data), 32'(vecs[i].e_data));
      check($sformatf("v%0d core_ack", i), 32'(core_ack), 32'(vecs[i].e_cack));
      check($sformatf("v%0d overflow", i), 32'(loader_overflow), 32'(vecs[i].e_ovf));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end
    loader_wr = 1'b0; core_req = 1'b0; core_addr = '0; core_data = '0;

    // overflow: five back-to-back words with memory stalled, the fifth is dropped
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      loader_wr = 1'b1;
      loader_addr = 15'(16 + 2 * i);
      loader_data = 16'(16'hA000 + i);
      step();
    end
    loader_wr = 1'b0;
    check("ovf sticky set", 32'(loader_overflow), 32'd1);
    mem_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (mem_wr) begin
        got_a.push_back(mem_addr);
        got_d.push_back(mem_data);
      end
      step();
    end
    check("ovf write count", 32'(got_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_a.size()) begin
        check($sformatf("ovf addr%0d", i), 32'(got_a[i]), 32'(16 + 2 * i));
        check($sformatf("ovf data%0d", i), 32'(got_d[i]), 32'(16'hA000 + i));
      end
    end
    check("ovf still set", 32'(loader_overflow), 32'd1);
    check("ovf busy done", 32'(busy), 32'd0);

    // reset asserted mid core write clears outputs immediately, no ack afterwards
    core_req = 1'b1; core_addr = 15'h055; core_data = 16'h1234; mem_ack = 1'b0;
    step();
    check("rstmid pre mem_wr", 32'(mem_wr), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid mem_wr", 32'(mem_wr), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid overflow", 32'(loader_overflow), 32'd0);
    core_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    mem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rstmid core_ack c%0d", c), 32'(core_ack), 32'd0);
      check($sformatf("rstmid mem_wr c%0d", c), 32'(mem_wr), 32'd0);
    end

    // contention: loader word in flight, a second queued, then core requests
    mem_ack = 1'b0;
    loader_wr = 1'b1; loader_addr = 15'h030; loader_data = 16'h3030;
    step();
    loader_wr = 1'b0;
    step();
    check("cont first grant", 32'(mem_addr), 32'h30);
    loader_wr = 1'b1; loader_addr = 15'h032; loader_data = 16'h3232;
    step();
    loader_wr = 1'b0;
    core_req = 1'b1; core_addr = 15'h040; core_data = 16'h4040;
    mem_ack = 1'b1;
    got_a.delete();
    got_d.delete();
    n_cack = 0;
    for (int c = 0; c < 14; c++) begin
      if (mem_wr) got_a.push_back(mem_addr);
      if (core_ack) begin
        n_cack++;
        core_req = 1'b0;
      end
      step();
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order[0] = 15'h030; exp_order[1] = 15'h040; exp_order[2] = 15'h032;
`else
    exp_order[0] = 15'h030; exp_order[1] = 15'h032; exp_order[2] = 15'h040;
`endif
    check("cont write count", 32'(got_a.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_a.size()) check($sformatf("cont order%0d", i), 32'(got_a[i]), 32'(exp_order[i]));
    end
    check("cont core_ack count", 32'(n_cack), 32'd1);
    check("cont busy done", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
